// File: rtl/t5_csr_pkg.sv
// t5 CSR unit shared definitions: CSR address map, funct3 encodings,
// mstatus bit positions and the address decoder used by the top.
package t5_csr_pkg;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MINSTR   = 12'hB02;
   localparam logic [11:0] A_MINSTRH  = 12'hB82;
   localparam logic [11:0] A_CYCLE    = 12'hC00;
   localparam logic [11:0] A_CYCLEH   = 12'hC80;
   localparam logic [11:0] A_INSTR    = 12'hC02;
   localparam logic [11:0] A_INSTRH   = 12'hC82;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   localparam logic [2:0] F3_RW  = 3'd1;
   localparam logic [2:0] F3_RS  = 3'd2;
   localparam logic [2:0] F3_RC  = 3'd3;
   localparam logic [2:0] F3_RWI = 3'd5;
   localparam logic [2:0] F3_RSI = 3'd6;
   localparam logic [2:0] F3_RCI = 3'd7;

   localparam int MST_MIE  = 3;
   localparam int MST_MPIE = 7;

   localparam logic [31:0] MISA_VAL = 32'h4000_0100;

   // Physical register selected by an address; the RO shadows alias the
   // machine counters and are told apart only by the ro flag.
   typedef enum logic [3:0] {
      SEL_NONE,
      SEL_MSTATUS,
      SEL_MISA,
      SEL_MTVEC,
      SEL_MSCRATCH,
      SEL_MEPC,
      SEL_MCAUSE,
      SEL_MTVAL,
      SEL_MCYC_LO,
      SEL_MCYC_HI,
      SEL_MINS_LO,
      SEL_MINS_HI,
      SEL_MHARTID
   } csr_sel_e;

   typedef struct packed {
      logic     vld;
      logic     ro;
      csr_sel_e sel;
   } csr_dec_t;

   function automatic csr_dec_t csr_decode(input logic [11:0] adr);
      csr_dec_t d;
      d.vld = 1'b1;
      d.ro  = 1'b0;
      d.sel = SEL_NONE;
      case (adr)
         A_MSTATUS:  d.sel = SEL_MSTATUS;
         A_MISA:     begin d.sel = SEL_MISA;    d.ro = 1'b1; end
         A_MTVEC:    d.sel = SEL_MTVEC;
         A_MSCRATCH: d.sel = SEL_MSCRATCH;
         A_MEPC:     d.sel = SEL_MEPC;
         A_MCAUSE:   d.sel = SEL_MCAUSE;
         A_MTVAL:    d.sel = SEL_MTVAL;
         A_MCYCLE:   d.sel = SEL_MCYC_LO;
         A_MCYCLEH:  d.sel = SEL_MCYC_HI;
         A_MINSTR:   d.sel = SEL_MINS_LO;
         A_MINSTRH:  d.sel = SEL_MINS_HI;
         A_CYCLE:    begin d.sel = SEL_MCYC_LO; d.ro = 1'b1; end
         A_CYCLEH:   begin d.sel = SEL_MCYC_HI; d.ro = 1'b1; end
         A_INSTR:    begin d.sel = SEL_MINS_LO; d.ro = 1'b1; end
         A_INSTRH:   begin d.sel = SEL_MINS_HI; d.ro = 1'b1; end
         A_MHARTID:  begin d.sel = SEL_MHARTID; d.ro = 1'b1; end
         default:    d.vld = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/t5_csr_hart.sv
// One hart's machine trap/scratch registers and its minstret counter.
// All enables arrive already qualified by pipeline advance and hart match.
module t5_csr_hart
   import t5_csr_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int CNTW = 64
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_wr_en,
   input  csr_sel_e        i_wr_sel,
   input  logic [XLEN-1:0] i_wr_data,
   input  logic            i_trp,
   input  logic            i_ret,
   input  logic            i_cmt,
   input  logic [3:0]      i_cause,
   input  logic [XLEN-3:0] i_epc,
   input  logic [XLEN-1:0] i_tval,
   output logic [XLEN-1:0] o_mstatus,
   output logic [XLEN-1:0] o_mtvec,
   output logic [XLEN-1:0] o_mscratch,
   output logic [XLEN-1:0] o_mepc,
   output logic [XLEN-1:0] o_mcause,
   output logic [XLEN-1:0] o_mtval,
   output logic [CNTW-1:0] o_minstret
);

   logic            r_mie;
   logic            r_mpie;
   logic [XLEN-3:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-3:0] r_mepc;
   logic [3:0]      r_mcause;
   logic [XLEN-1:0] r_mtval;
   logic [CNTW-1:0] r_minstret;

   logic w_wr_mstatus, w_wr_mtvec, w_wr_mscratch, w_wr_mepc;
   logic w_wr_mcause, w_wr_mtval, w_wr_ins_lo, w_wr_ins_hi;

   assign w_wr_mstatus  = i_wr_en && (i_wr_sel == SEL_MSTATUS);
   assign w_wr_mtvec    = i_wr_en && (i_wr_sel == SEL_MTVEC);
   assign w_wr_mscratch = i_wr_en && (i_wr_sel == SEL_MSCRATCH);
   assign w_wr_mepc     = i_wr_en && (i_wr_sel == SEL_MEPC);
   assign w_wr_mcause   = i_wr_en && (i_wr_sel == SEL_MCAUSE);
   assign w_wr_mtval    = i_wr_en && (i_wr_sel == SEL_MTVAL);
   assign w_wr_ins_lo   = i_wr_en && (i_wr_sel == SEL_MINS_LO);
   assign w_wr_ins_hi   = i_wr_en && (i_wr_sel == SEL_MINS_HI);

   // Interrupt-enable stack: trap pushes, MRET pops, CSR write lowest priority.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mie  <= 1'b0;
         r_mpie <= 1'b0;
      end else if (i_trp) begin
         r_mpie <= r_mie;
         r_mie  <= 1'b0;
      end else if (i_ret) begin
         r_mie  <= r_mpie;
         r_mpie <= 1'b1;
      end else if (w_wr_mstatus) begin
         r_mie  <= i_wr_data[MST_MIE];
         r_mpie <= i_wr_data[MST_MPIE];
      end
   end

   // Software-only registers: trap vector and scratch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mtvec    <= '0;
         r_mscratch <= '0;
      end else begin
         if (w_wr_mtvec)    r_mtvec    <= i_wr_data[XLEN-1:2];
         if (w_wr_mscratch) r_mscratch <= i_wr_data;
      end
   end

   // Trap capture registers; a committing trap overrides a same-cycle CSR write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mepc   <= '0;
         r_mcause <= '0;
         r_mtval  <= '0;
      end else if (i_trp) begin
         r_mepc   <= i_epc;
         r_mcause <= i_cause;
         r_mtval  <= i_tval;
      end else begin
         if (w_wr_mepc)   r_mepc   <= i_wr_data[XLEN-1:2];
         if (w_wr_mcause) r_mcause <= i_wr_data[3:0];
         if (w_wr_mtval)  r_mtval  <= i_wr_data;
      end
   end

   // Retired-instruction counter; a write to either half replaces the increment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_minstret <= '0;
      end else if (w_wr_ins_lo) begin
         r_minstret <= {r_minstret[CNTW-1:32], i_wr_data};
      end else if (w_wr_ins_hi) begin
         r_minstret <= {i_wr_data[CNTW-33:0], r_minstret[31:0]};
      end else if (i_cmt) begin
         r_minstret <= r_minstret + 1'b1;
      end
   end

   // Architectural views with unimplemented bits reading zero.
   always_comb begin
      o_mstatus           = '0;
      o_mstatus[MST_MIE]  = r_mie;
      o_mstatus[MST_MPIE] = r_mpie;
   end

   assign o_mtvec    = {r_mtvec, 2'b00};
   assign o_mscratch = r_mscratch;
   assign o_mepc     = {r_mepc, 2'b00};
   assign o_mcause   = {{(XLEN-4){1'b0}}, r_mcause};
   assign o_mtval    = r_mtval;
   assign o_minstret = r_minstret;

endmodule

// File: rtl/t5_csru.sv
// t5 multi-hart machine-mode CSR unit: decode/legality of CSR instructions,
// read mux, shared mcycle, registered read data and per-hart register sets.
module t5_csru
   import t5_csr_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NHART = 4,
   parameter int HW    = 2,
   parameter int CNTW  = 64
) (
   input  logic            sclk,
   input  logic            srst,
   input  logic            sena,
   input  logic            dcsr,
   input  logic [HW-1:0]   dhart,
   input  logic [2:0]      dfn3,
   input  logic [11:0]     dadr,
   input  logic [XLEN-1:0] dop1,
   input  logic [4:0]      dimm,
   input  logic            xtrp,
   input  logic            xret,
   input  logic            xcmt,
   input  logic [HW-1:0]   xhart,
   input  logic [3:0]      xcause,
   input  logic [XLEN-3:0] xepc,
   input  logic [XLEN-1:0] xtval,
   output logic [XLEN-1:0] xcsr,
   output logic            xill,
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] mepc
);

   // Slots for every encodable hart id; ids beyond NHART read as zero.
   localparam int NSLOT = 2**HW;

   logic [XLEN-1:0] w_mstatus  [NSLOT];
   logic [XLEN-1:0] w_mtvec    [NSLOT];
   logic [XLEN-1:0] w_mscratch [NSLOT];
   logic [XLEN-1:0] w_mepc     [NSLOT];
   logic [XLEN-1:0] w_mcause   [NSLOT];
   logic [XLEN-1:0] w_mtval    [NSLOT];
   logic [CNTW-1:0] w_minstret [NSLOT];

   logic [CNTW-1:0] r_mcycle;
   logic [XLEN-1:0] r_xcsr;
   logic            r_xill;

   csr_dec_t        w_dec;
   logic [XLEN-1:0] w_mask;
   logic [XLEN-1:0] w_old;
   logic [XLEN-1:0] w_new;
   logic            w_fn_ok;
   logic            w_is_rw;
   logic            w_wreq;
   logic            w_ill;
   logic            w_we;
   logic            w_wr_cyc_lo;
   logic            w_wr_cyc_hi;

   assign w_dec   = csr_decode(dadr);
   assign w_mask  = dfn3[2] ? {{(XLEN-5){1'b0}}, dimm} : dop1;
   // funct3 0 and 4 are not CSR operations.
   assign w_fn_ok = (dfn3[1:0] != 2'b00);
   assign w_is_rw = (dfn3[1:0] == 2'b01);
   // Set/clear with an all-zero mask is a pure read, so it is legal on RO registers.
   assign w_wreq  = w_is_rw || (w_mask != '0);
   assign w_ill   = dcsr && (!w_dec.vld || !w_fn_ok || (w_wreq && w_dec.ro));
   assign w_we    = sena && dcsr && !w_ill && w_wreq;

   assign w_wr_cyc_lo = w_we && (w_dec.sel == SEL_MCYC_LO);
   assign w_wr_cyc_hi = w_we && (w_dec.sel == SEL_MCYC_HI);

   // Old-value read mux for the decode-stage hart.
   always_comb begin
      w_old = '0;
      case (w_dec.sel)
         SEL_MSTATUS:  w_old = w_mstatus[dhart];
         SEL_MISA:     w_old = MISA_VAL;
         SEL_MTVEC:    w_old = w_mtvec[dhart];
         SEL_MSCRATCH: w_old = w_mscratch[dhart];
         SEL_MEPC:     w_old = w_mepc[dhart];
         SEL_MCAUSE:   w_old = w_mcause[dhart];
         SEL_MTVAL:    w_old = w_mtval[dhart];
         SEL_MCYC_LO:  w_old = r_mcycle[31:0];
         SEL_MCYC_HI:  w_old = XLEN'(r_mcycle >> 32);
         SEL_MINS_LO:  w_old = w_minstret[dhart][31:0];
         SEL_MINS_HI:  w_old = XLEN'(w_minstret[dhart] >> 32);
         SEL_MHARTID:  w_old = XLEN'(dhart);
         default:      w_old = '0;
      endcase
   end

   // Read-modify-write value for RW/RS/RC and their immediate forms.
   always_comb begin
      w_new = w_mask;
      case (dfn3[1:0])
         2'b10:   w_new = w_old | w_mask;
         2'b11:   w_new = w_old & ~w_mask;
         default: w_new = w_mask;
      endcase
   end

   // Shared cycle counter; a write to either half replaces that cycle's increment.
   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         r_mcycle <= '0;
      end else if (sena) begin
         if (w_wr_cyc_lo)
            r_mcycle <= {r_mcycle[CNTW-1:32], w_new};
         else if (w_wr_cyc_hi)
            r_mcycle <= {w_new[CNTW-33:0], r_mcycle[31:0]};
         else
            r_mcycle <= r_mcycle + 1'b1;
      end
   end

   // Registered read data and illegal flag; both hold while the pipe stalls.
   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         r_xcsr <= '0;
         r_xill <= 1'b0;
      end else if (sena) begin
         r_xill <= w_ill;
         r_xcsr <= (dcsr && !w_ill) ? w_old : '0;
      end
   end

   assign xcsr  = r_xcsr;
   assign xill  = r_xill;
   assign mtvec = w_mtvec[xhart];
   assign mepc  = w_mepc[xhart];

   for (genvar g = 0; g < NSLOT; g++) begin : g_hart
      if (g < NHART) begin : g_on
         t5_csr_hart #(
            .XLEN (XLEN),
            .CNTW (CNTW)
         ) u_hart (
            .i_clk      (sclk),
            .i_rst_n    (srst),
            .i_wr_en    (w_we && (dhart == HW'(g))),
            .i_wr_sel   (w_dec.sel),
            .i_wr_data  (w_new),
            .i_trp      (sena && xtrp && (xhart == HW'(g))),
            .i_ret      (sena && xret && !xtrp && (xhart == HW'(g))),
            .i_cmt      (sena && xcmt && (xhart == HW'(g))),
            .i_cause    (xcause),
            .i_epc      (xepc),
            .i_tval     (xtval),
            .o_mstatus  (w_mstatus[g]),
            .o_mtvec    (w_mtvec[g]),
            .o_mscratch (w_mscratch[g]),
            .o_mepc     (w_mepc[g]),
            .o_mcause   (w_mcause[g]),
            .o_mtval    (w_mtval[g]),
            .o_minstret (w_minstret[g])
         );
      end else begin : g_off
         assign w_mstatus[g]  = '0;
         assign w_mtvec[g]    = '0;
         assign w_mscratch[g] = '0;
         assign w_mepc[g]     = '0;
         assign w_mcause[g]   = '0;
         assign w_mtval[g]    = '0;
         assign w_minstret[g] = '0;
      end
   end

endmodule

// File: tb/tb_t5_csru.sv
// Bench for t5_csru: directed scenarios plus randomized traffic, checked
// against an architectural model of the per-hart CSR state.
module tb_t5_csru;

   logic        sclk = 1'b0;
   logic        srst = 1'b0;
   logic        sena = 1'b1;
   logic        dcsr = 1'b0;
   logic [1:0]  dhart = '0;
   logic [2:0]  dfn3 = '0;
   logic [11:0] dadr = '0;
   logic [31:0] dop1 = '0;
   logic [4:0]  dimm = '0;
   logic        xtrp = 1'b0;
   logic        xret = 1'b0;
   logic        xcmt = 1'b0;
   logic [1:0]  xhart = '0;
   logic [3:0]  xcause = '0;
   logic [29:0] xepc = '0;
   logic [31:0] xtval = '0;
   logic [31:0] xcsr;
   logic        xill;
   logic [31:0] mtvec;
   logic [31:0] mepc;

   int n_chk = 0;
   int n_err = 0;

   // Architectural model state
   logic [63:0] m_cyc;
   logic [63:0] m_ins   [4];
   logic        m_mie   [4];
   logic        m_mpie  [4];
   logic [31:0] m_tvec  [4];
   logic [31:0] m_scr   [4];
   logic [31:0] m_epc   [4];
   logic [3:0]  m_cause [4];
   logic [31:0] m_tval  [4];
   logic [31:0] e_xcsr = '0;
   logic        e_xill = 1'b0;

   t5_csru #(.XLEN(32), .NHART(4), .HW(2), .CNTW(64)) dut (
      .sclk(sclk), .srst(srst), .sena(sena), .dcsr(dcsr), .dhart(dhart),
      .dfn3(dfn3), .dadr(dadr), .dop1(dop1), .dimm(dimm), .xtrp(xtrp),
      .xret(xret), .xcmt(xcmt), .xhart(xhart), .xcause(xcause), .xepc(xepc),
      .xtval(xtval), .xcsr(xcsr), .xill(xill), .mtvec(mtvec), .mepc(mepc)
   );

   always #5 sclk = ~sclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      m_cyc = '0;
      for (int h = 0; h < 4; h++) begin
         m_ins[h] = '0; m_mie[h] = 1'b0; m_mpie[h] = 1'b0; m_tvec[h] = '0;
         m_scr[h] = '0; m_epc[h] = '0; m_cause[h] = '0; m_tval[h] = '0;
      end
      e_xcsr = '0;
      e_xill = 1'b0;
   endtask

   task automatic mdl_read(input logic [11:0] a, input logic [1:0] h,
                           output bit known, output bit ro, output logic [31:0] v);
      known = 1; ro = 0; v = '0;
      case (a)
         12'h300: v = {24'd0, m_mpie[h], 3'd0, m_mie[h], 3'd0};
         12'h301: begin v = 32'h4000_0100; ro = 1; end
         12'h305: v = m_tvec[h];
         12'h340: v = m_scr[h];
         12'h341: v = m_epc[h];
         12'h342: v = {28'd0, m_cause[h]};
         12'h343: v = m_tval[h];
         12'hB00: v = m_cyc[31:0];
         12'hB80: v = m_cyc[63:32];
         12'hB02: v = m_ins[h][31:0];
         12'hB82: v = m_ins[h][63:32];
         12'hC00: begin v = m_cyc[31:0];     ro = 1; end
         12'hC80: begin v = m_cyc[63:32];    ro = 1; end
         12'hC02: begin v = m_ins[h][31:0];  ro = 1; end
         12'hC82: begin v = m_ins[h][63:32]; ro = 1; end
         12'hF14: begin v = {30'd0, h};      ro = 1; end
         default: known = 0;
      endcase
   endtask

   task automatic mdl_write(input logic [11:0] a, input logic [1:0] h, input logic [31:0] v,
                            output bit wc, output bit wi);
      wc = 0; wi = 0;
      case (a)
         12'h300: begin m_mie[h] = v[3]; m_mpie[h] = v[7]; end
         12'h305: m_tvec[h] = v & ~32'h3;
         12'h340: m_scr[h] = v;
         12'h341: m_epc[h] = v & ~32'h3;
         12'h342: m_cause[h] = v[3:0];
         12'h343: m_tval[h] = v;
         12'hB00: begin m_cyc[31:0] = v;     wc = 1; end
         12'hB80: begin m_cyc[63:32] = v;    wc = 1; end
         12'hB02: begin m_ins[h][31:0] = v;  wi = 1; end
         12'hB82: begin m_ins[h][63:32] = v; wi = 1; end
         default: ;
      endcase
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic mdl_step();
      logic [31:0] old, msk, nv;
      bit known, ro, fnok, wreq, ill, wc, wi;
      logic o_mie, o_mpie;
      if (!sena) return;
      wc = 0; wi = 0;
      o_mie  = m_mie[xhart];
      o_mpie = m_mpie[xhart];
      e_xcsr = '0;
      e_xill = 1'b0;
      if (dcsr) begin
         mdl_read(dadr, dhart, known, ro, old);
         fnok = (dfn3 != 3'd0) && (dfn3 != 3'd4);
         msk  = dfn3[2] ? {27'd0, dimm} : dop1;
         wreq = (dfn3 == 3'd1) || (dfn3 == 3'd5) || (msk != 0);
         ill  = !known || !fnok || (wreq && ro);
         e_xill = ill;
         if (!ill) begin
            e_xcsr = old;
            if (wreq) begin
               case (dfn3)
                  3'd1, 3'd5: nv = msk;
                  3'd2, 3'd6: nv = old | msk;
                  default:    nv = old & ~msk;
               endcase
               mdl_write(dadr, dhart, nv, wc, wi);
            end
         end
      end
      if (xtrp) begin
         m_epc[xhart] = {xepc, 2'b00}; m_cause[xhart] = xcause; m_tval[xhart] = xtval;
         m_mpie[xhart] = o_mie; m_mie[xhart] = 1'b0;
      end else if (xret) begin
         m_mie[xhart] = o_mpie; m_mpie[xhart] = 1'b1;
      end
      if (!wc) m_cyc = m_cyc + 1;
      if (xcmt && !(wi && dhart == xhart)) m_ins[xhart] = m_ins[xhart] + 1;
   endtask

   task automatic tick();
      mdl_step();
      @(posedge sclk);
      #1;
      chk("xcsr", xcsr, e_xcsr);
      chk("xill", xill, e_xill);
      chk("mtvec", mtvec, m_tvec[xhart]);
      chk("mepc", mepc, m_epc[xhart]);
   endtask

   task automatic csr_op(input logic [1:0] h, input logic [2:0] f, input logic [11:0] a,
                         input logic [31:0] o, input logic [4:0] im);
      dcsr = 1'b1; dhart = h; dfn3 = f; dadr = a; dop1 = o; dimm = im;
      tick();
      dcsr = 1'b0;
   endtask

   logic [11:0] adrs [16];

   initial begin
      adrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00,
               12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14};
      mdl_reset();
      repeat (3) @(posedge sclk);
      #1;
      chk("rst_xcsr", xcsr, 0);
      chk("rst_xill", xill, 0);
      chk("rst_mtvec", mtvec, 0);
      chk("rst_mepc", mepc, 0);
      @(negedge sclk);
      srst = 1'b1;

      // Reset values and misa
      csr_op(0, 3'd2, 12'h301, 0, 0);
      chk("misa", xcsr, 32'h4000_0100);

      // Per-hart isolation of mscratch
      csr_op(1, 3'd1, 12'h340, 32'hDEAD_BEEF, 0);
      csr_op(1, 3'd2, 12'h340, 0, 0);
      chk("scr_h1", xcsr, 32'hDEAD_BEEF);
      csr_op(2, 3'd2, 12'h340, 0, 0);
      chk("scr_h2", xcsr, 0);

      // Set then clear MIE
      csr_op(0, 3'd6, 12'h300, 0, 5'd8);
      chk("rsi_old", xcsr, 0);
      csr_op(0, 3'd3, 12'h300, 32'd8, 0);
      chk("rc_old", xcsr, 32'h8);

      // Trap then MRET on hart 0
      csr_op(0, 3'd6, 12'h300, 0, 5'd8);
      xtrp = 1'b1; xhart = 2'd0; xepc = 30'h40; xcause = 4'd2; xtval = 32'h1234;
      tick();
      xtrp = 1'b0;
      chk("trap_mepc", mepc, 32'h100);
      csr_op(0, 3'd2, 12'h342, 0, 0);
      chk("trap_mcause", xcsr, 32'h2);
      csr_op(0, 3'd2, 12'h300, 0, 0);
      chk("trap_mstatus", xcsr, 32'h80);
      xret = 1'b1;
      tick();
      xret = 1'b0;
      csr_op(0, 3'd2, 12'h300, 0, 0);
      chk("mret_mstatus", xcsr, 32'h88);

      // Trap and mepc write collide on the same hart
      xtrp = 1'b1; xhart = 2'd0; xepc = 30'h80; xcause = 4'd5;
      csr_op(0, 3'd1, 12'h341, 32'h40, 0);
      xtrp = 1'b0;
      chk("coll_mepc", mepc, 32'h200);
      csr_op(1, 3'd1, 12'hF14, 32'd5, 0);
      chk("ro_wr_xill", xill, 1);
      chk("ro_wr_xcsr", xcsr, 0);
      csr_op(3, 3'd2, 12'hF14, 0, 0);
      chk("ro_rd_xill", xill, 0);
      chk("mhartid", xcsr, 3);

      // Counter wrap and per-hart minstret
      csr_op(0, 3'd1, 12'hB00, 32'hFFFF_FFFF, 0);
      csr_op(0, 3'd1, 12'hB80, 32'hFFFF_FFFF, 0);
      tick();
      csr_op(0, 3'd2, 12'hB00, 0, 0);
      chk("cyc_lo_wrap", xcsr, 0);
      csr_op(0, 3'd2, 12'hB80, 0, 0);
      chk("cyc_hi_wrap", xcsr, 0);
      xcmt = 1'b1; xhart = 2'd3;
      tick();
      xcmt = 1'b0;
      csr_op(3, 3'd2, 12'hB02, 0, 0);
      chk("ins_h3", xcsr, 1);
      csr_op(2, 3'd2, 12'hC02, 0, 0);
      chk("ins_h2", xcsr, 0);

      // Stall holds read data
      csr_op(0, 3'd2, 12'h301, 0, 0);
      sena = 1'b0;
      csr_op(1, 3'd2, 12'h340, 0, 0);
      chk("stall_hold", xcsr, 32'h4000_0100);
      sena = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         sena   = ($urandom_range(0, 9) != 0);
         dcsr   = ($urandom_range(0, 2) != 0);
         dhart  = 2'($urandom);
         dfn3   = 3'($urandom);
         dadr   = ($urandom_range(0, 9) == 0) ? 12'($urandom) : adrs[$urandom_range(0, 15)];
         dop1   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         dimm   = 5'($urandom);
         xtrp   = ($urandom_range(0, 9) == 0);
         xret   = ($urandom_range(0, 7) == 0);
         xcmt   = 1'($urandom);
         xhart  = 2'($urandom);
         xcause = 4'($urandom);
         xepc   = 30'($urandom);
         xtval  = $urandom;
         tick();
      end

      // Asynchronous reset in the middle of operation
      sena = 1'b1; dcsr = 1'b0; xtrp = 1'b0; xret = 1'b0; xcmt = 1'b0;
      @(posedge sclk);
      #3;
      srst = 1'b0;
      #1;
      chk("arst_xcsr", xcsr, 0);
      chk("arst_xill", xill, 0);
      for (int h = 0; h < 4; h++) begin
         xhart = 2'(h);
         #1;
         chk("arst_mtvec", mtvec, 0);
         chk("arst_mepc", mepc, 0);
      end
      mdl_reset();
      @(negedge sclk);
      srst = 1'b1;
      csr_op(1, 3'd2, 12'h340, 0, 0);
      chk("arst_scr", xcsr, 0);
      csr_op(0, 3'd2, 12'hB00, 0, 0);
      csr_op(2, 3'd2, 12'h343, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
